// File: rtl/adbg_jsp_uart_ctrl.sv
// adbg_jsp_uart_ctrl
// CPU-side 16550-style register file and interrupt controller for the JTAG
// Serial Port. Decodes 8-bit register accesses, pops/pushes/flushes the
// first-word-fall-through Rx/Tx FIFOs, and reports LSR/IIR/MSR status and a
// registered interrupt request.

module adbg_jsp_uart_ctrl #(
   parameter int RX_CNT_W    = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic              clk_i,
   input  logic              rst_i,
   // CPU register port
   input  logic              cpu_stb_i,
   input  logic              cpu_we_i,
   input  logic [2:0]        cpu_adr_i,
   input  logic [7:0]        cpu_dat_i,
   output logic [7:0]        cpu_dat_o,
   output logic              cpu_ack_o,
   output logic              int_o,
   // Rx FIFO (read side)
   input  logic [7:0]        rx_dat_i,
   input  logic              rx_empty_i,
   input  logic [RX_CNT_W:0] rx_cnt_i,
   output logic              rx_pop_o,
   output logic              rx_flush_o,
   // Tx FIFO (write side)
   output logic [7:0]        tx_dat_o,
   output logic              tx_push_o,
   input  logic              tx_full_i,
   input  logic              tx_empty_i,
   output logic              tx_flush_o
);

   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC);

   localparam logic [2:0] A_RBR = 3'd0;
   localparam logic [2:0] A_IER = 3'd1;
   localparam logic [2:0] A_IIR = 3'd2;
   localparam logic [2:0] A_LCR = 3'd3;
   localparam logic [2:0] A_MCR = 3'd4;
   localparam logic [2:0] A_LSR = 3'd5;
   localparam logic [2:0] A_MSR = 3'd6;
   localparam logic [2:0] A_SCR = 3'd7;

   // Interrupt identification codes as reported in IIR[3:1]
   typedef enum logic [2:0] {
      ID_NONE = 3'b000,
      ID_THRE = 3'b001,
      ID_RDA  = 3'b010,
      ID_CTI  = 3'b110
   } iid_e;

   // Architectural registers
   logic [3:0]      r_ier;
   logic [7:0]      r_lcr;
   logic [4:0]      r_mcr;
   logic [7:0]      r_scr;
   logic [7:0]      r_dll;
   logic [7:0]      r_dlm;
   logic            r_fifo_ena;
   logic [1:0]      r_rx_trig;
   logic            r_thre;
   logic [TO_W-1:0] r_to_cnt;

   // History of status inputs for edge / change detection
   logic [RX_CNT_W:0] r_rx_cnt_q;
   logic              r_tx_empty_q;

   // Registered outputs
   logic       r_ack;
   logic [7:0] r_dat;
   logic       r_rx_pop;
   logic       r_rx_flush;
   logic       r_tx_push;
   logic [7:0] r_tx_dat;
   logic       r_tx_flush;
   logic       r_int;

   // Access decode
   logic w_accept, w_rd, w_wr, w_dlab;
   logic w_rbr_rd, w_thr_wr, w_ier_wr, w_iir_rd, w_fcr_wr;

   assign w_accept = cpu_stb_i && !r_ack;
   assign w_rd     = w_accept && !cpu_we_i;
   assign w_wr     = w_accept &&  cpu_we_i;
   assign w_dlab   = r_lcr[7];

   assign w_rbr_rd = w_rd && (cpu_adr_i == A_RBR) && !w_dlab;
   assign w_thr_wr = w_wr && (cpu_adr_i == A_RBR) && !w_dlab;
   assign w_ier_wr = w_wr && (cpu_adr_i == A_IER) && !w_dlab;
   assign w_iir_rd = w_rd && (cpu_adr_i == A_IIR);
   assign w_fcr_wr = w_wr && (cpu_adr_i == A_IIR);

   // Status and interrupt sources
   logic [31:0] w_trig_lvl;
   logic        w_rda, w_cti, w_thre_int, w_ip;
   iid_e        w_iid;
   logic [7:0]  w_iir, w_lsr, w_msr, w_rdata;

   // Rx trigger level decode
   // NOTE: every signal driven in an always_comb gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      w_trig_lvl = 32'd14;
      case (r_rx_trig)
         2'b00:   w_trig_lvl = 32'd1;
         2'b01:   w_trig_lvl = 32'd4;
         2'b10:   w_trig_lvl = 32'd8;
         default: w_trig_lvl = 32'd14;
      endcase
   end

   assign w_rda      = r_ier[0] && (32'(rx_cnt_i) >= w_trig_lvl);
   assign w_cti      = r_ier[0] && !rx_empty_i && (r_to_cnt == TO_MAX);
   assign w_thre_int = r_ier[1] && r_thre;

   // Fixed-priority interrupt identification: RDA, then CTI, then THRE
   always_comb begin
      w_ip  = 1'b0;
      w_iid = ID_NONE;
      if (w_rda)           w_iid = ID_RDA;
      else if (w_cti)      w_iid = ID_CTI;
      else if (w_thre_int) w_iid = ID_THRE;
      else                 w_ip  = 1'b1;
   end

   assign w_iir = {{2{r_fifo_ena}}, 2'b00, w_iid, w_ip};
   assign w_lsr = {1'b0, tx_empty_i, tx_empty_i, 4'h0, !rx_empty_i};
   // In loopback the modem inputs mirror the MCR outputs; otherwise the
   // "cable" is always connected and ready.
   assign w_msr = r_mcr[4] ? {r_mcr[3], r_mcr[2], r_mcr[0], r_mcr[1], 4'h0}
                           : 8'hB0;

   // Read-data multiplexer, evaluated at acceptance
   always_comb begin
      w_rdata = 8'h00;
      case (cpu_adr_i)
         A_RBR:   w_rdata = w_dlab ? r_dll : rx_dat_i;
         A_IER:   w_rdata = w_dlab ? r_dlm : {4'h0, r_ier};
         A_IIR:   w_rdata = w_iir;
         A_LCR:   w_rdata = r_lcr;
         A_MCR:   w_rdata = {3'b000, r_mcr};
         A_LSR:   w_rdata = w_lsr;
         A_MSR:   w_rdata = w_msr;
         A_SCR:   w_rdata = r_scr;
         default: w_rdata = 8'h00;
      endcase
   end

   // Bus handshake: one-cycle ack, captured read data and FIFO side-effect pulses
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ack      <= 1'b0;
         r_dat      <= 8'h00;
         r_rx_pop   <= 1'b0;
         r_rx_flush <= 1'b0;
         r_tx_push  <= 1'b0;
         r_tx_dat   <= 8'h00;
         r_tx_flush <= 1'b0;
      end else begin
         r_ack      <= w_accept;
         r_dat      <= w_rd ? w_rdata : 8'h00;
         r_rx_pop   <= w_rbr_rd && !rx_empty_i;
         r_tx_push  <= w_thr_wr && !tx_full_i;
         r_rx_flush <= w_fcr_wr && cpu_dat_i[1];
         r_tx_flush <= w_fcr_wr && cpu_dat_i[2];
         if (w_thr_wr && !tx_full_i) begin
            r_tx_dat <= cpu_dat_i;
         end
      end
   end

   // Register-file writes
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ier      <= 4'h0;
         r_lcr      <= 8'h03;
         r_mcr      <= 5'h00;
         r_scr      <= 8'h00;
         r_dll      <= 8'h01;
         r_dlm      <= 8'h00;
         r_fifo_ena <= 1'b0;
         r_rx_trig  <= 2'b11;
      end else if (w_wr) begin
         case (cpu_adr_i)
            A_RBR: if (w_dlab) r_dll <= cpu_dat_i;
            A_IER: begin
               if (w_dlab) r_dlm <= cpu_dat_i;
               else        r_ier <= cpu_dat_i[3:0];
            end
            A_IIR: begin
               r_fifo_ena <= cpu_dat_i[0];
               r_rx_trig  <= cpu_dat_i[7:6];
            end
            A_LCR:   r_lcr <= cpu_dat_i;
            A_MCR:   r_mcr <= cpu_dat_i[4:0];
            A_SCR:   r_scr <= cpu_dat_i;
            default: ;
         endcase
      end
   end

   // THRE interrupt latch; a clear beats a simultaneous set
   logic w_thre_set, w_thre_clr;

   assign w_thre_set = (tx_empty_i && !r_tx_empty_q) ||
                       (w_ier_wr && !r_ier[1] && cpu_dat_i[1] && tx_empty_i);
   assign w_thre_clr = w_thr_wr || (w_iir_rd && !w_ip && (w_iid == ID_THRE));

   // Track tx_empty_i history and update the THRE latch
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_thre       <= 1'b0;
         // Treat the FIFO as already empty so reset itself is not an edge.
         r_tx_empty_q <= 1'b1;
      end else begin
         r_tx_empty_q <= tx_empty_i;
         if (w_thre_clr)      r_thre <= 1'b0;
         else if (w_thre_set) r_thre <= 1'b1;
      end
   end

   // Character-timeout counter: restarts on any Rx activity, saturates at the limit
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_to_cnt   <= '0;
         r_rx_cnt_q <= '0;
      end else begin
         r_rx_cnt_q <= rx_cnt_i;
         if (rx_empty_i || w_rbr_rd || (rx_cnt_i != r_rx_cnt_q)) begin
            r_to_cnt <= '0;
         end else if (r_to_cnt != TO_MAX) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
         end
      end
   end

   // Registered interrupt request
   always_ff @(posedge clk_i) begin
      if (rst_i) r_int <= 1'b0;
      else       r_int <= !w_ip;
   end

   assign cpu_ack_o  = r_ack;
   assign cpu_dat_o  = r_dat;
   assign int_o      = r_int;
   assign rx_pop_o   = r_rx_pop;
   assign rx_flush_o = r_rx_flush;
   assign tx_dat_o   = r_tx_dat;
   assign tx_push_o  = r_tx_push;
   assign tx_flush_o = r_tx_flush;

endmodule

// File: tb/tb_adbg_jsp_uart_ctrl.sv
// Testbench for adbg_jsp_uart_ctrl: per-feature tasks driving CPU accesses
// and FIFO status; expected read data and pulses go into a scoreboard queue
// when an access is issued and are compared when the DUT acknowledges it.

module tb_adbg_jsp_uart_ctrl;

   localparam int RX_CNT_W    = 4;
   localparam int TIMEOUT_CYC = 1024;

   localparam logic [3:0] P_NONE = 4'b0000;
   localparam logic [3:0] P_POP  = 4'b1000;
   localparam logic [3:0] P_PUSH = 4'b0100;
   localparam logic [3:0] P_RXF  = 4'b0010;
   localparam logic [3:0] P_TXF  = 4'b0001;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              cpu_stb_i;
   logic              cpu_we_i;
   logic [2:0]        cpu_adr_i;
   logic [7:0]        cpu_dat_i;
   logic [7:0]        cpu_dat_o;
   logic              cpu_ack_o;
   logic              int_o;
   logic [7:0]        rx_dat_i;
   logic              rx_empty_i;
   logic [RX_CNT_W:0] rx_cnt_i;
   logic              rx_pop_o;
   logic              rx_flush_o;
   logic [7:0]        tx_dat_o;
   logic              tx_push_o;
   logic              tx_full_i;
   logic              tx_empty_i;
   logic              tx_flush_o;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       we;
      logic [7:0] wdat;
      logic [7:0] rdat;
      logic [3:0] pulses;
   } txn_t;

   txn_t sb_q[$];

   always #5 clk_i = ~clk_i;

   adbg_jsp_uart_ctrl #(
      .RX_CNT_W   (RX_CNT_W),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .cpu_stb_i (cpu_stb_i),
      .cpu_we_i  (cpu_we_i),
      .cpu_adr_i (cpu_adr_i),
      .cpu_dat_i (cpu_dat_i),
      .cpu_dat_o (cpu_dat_o),
      .cpu_ack_o (cpu_ack_o),
      .int_o     (int_o),
      .rx_dat_i  (rx_dat_i),
      .rx_empty_i(rx_empty_i),
      .rx_cnt_i  (rx_cnt_i),
      .rx_pop_o  (rx_pop_o),
      .rx_flush_o(rx_flush_o),
      .tx_dat_o  (tx_dat_o),
      .tx_push_o (tx_push_o),
      .tx_full_i (tx_full_i),
      .tx_empty_i(tx_empty_i),
      .tx_flush_o(tx_flush_o)
   );

   function automatic logic [3:0] pulses_now();
      return {rx_pop_o, tx_push_o, rx_flush_o, tx_flush_o};
   endfunction

   // One CPU access, called at a falling edge; returns at a falling edge.
   task automatic bus(input logic we, input logic [2:0] adr, input logic [7:0] wdat,
                      input logic [7:0] exp_rd, input logic [3:0] exp_pl, input string name);
      txn_t t;
      int   waited;
      t.we = we; t.wdat = wdat; t.rdat = exp_rd; t.pulses = exp_pl;
      sb_q.push_back(t);
      cpu_we_i  = we;
      cpu_adr_i = adr;
      cpu_dat_i = wdat;
      cpu_stb_i = 1'b1;
      waited = 0;
      @(negedge clk_i);
      while (cpu_ack_o !== 1'b1 && waited < 8) begin
         @(negedge clk_i);
         waited++;
      end
      cpu_stb_i = 1'b0;
      t = sb_q.pop_front();
      checks++;
      if (cpu_ack_o !== 1'b1 || waited != 0) begin
         errors++;
         $display("FAIL %s ack: ack=%b after %0d extra cycles, required ack one cycle after stb",
                  name, cpu_ack_o, waited);
      end
      if (cpu_ack_o === 1'b1) begin
         if (!t.we) begin
            checks++;
            if (cpu_dat_o !== t.rdat) begin
               errors++;
               $display("FAIL %s rdata: got 0x%02h, required 0x%02h", name, cpu_dat_o, t.rdat);
            end
         end
         checks++;
         if (pulses_now() !== t.pulses) begin
            errors++;
            $display("FAIL %s pulses{pop,push,rxf,txf}: got %b, required %b",
                     name, pulses_now(), t.pulses);
         end
         if (t.pulses[2]) begin
            checks++;
            if (tx_dat_o !== t.wdat) begin
               errors++;
               $display("FAIL %s tx_dat: got 0x%02h, required 0x%02h", name, tx_dat_o, t.wdat);
            end
         end
      end
      @(negedge clk_i);
      checks++;
      if (cpu_ack_o !== 1'b0 || pulses_now() !== 4'b0000 || cpu_dat_o !== 8'h00) begin
         errors++;
         $display("FAIL %s idle after ack: ack=%b pulses=%b dat=0x%02h, required 0/0000/0x00",
                  name, cpu_ack_o, pulses_now(), cpu_dat_o);
      end
   endtask

   task automatic expect_int(input logic exp, input string name);
      checks++;
      if (int_o !== exp) begin
         errors++;
         $display("FAIL %s int_o: got %b, required %b", name, int_o, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      for (int i = 0; i < n; i++) @(negedge clk_i);
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      @(negedge clk_i);
      // An FCR write presented during reset must be aborted.
      cpu_we_i = 1'b1; cpu_adr_i = 3'd2; cpu_dat_i = 8'h07; cpu_stb_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk_i);
         checks++;
         if (cpu_ack_o !== 1'b0 || pulses_now() !== 4'b0000 || cpu_dat_o !== 8'h00 || int_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: ack=%b pulses=%b dat=0x%02h int=%b, required all 0",
                     cpu_ack_o, pulses_now(), cpu_dat_o, int_o);
         end
      end
      cpu_stb_i = 1'b0;
      rst_i = 1'b0;
      @(negedge clk_i);
      bus(0, 3'd3, 8'h00, 8'h03, P_NONE, "rst_lcr");
      bus(0, 3'd2, 8'h00, 8'h01, P_NONE, "rst_iir");
      bus(0, 3'd5, 8'h00, 8'h60, P_NONE, "rst_lsr");
      bus(0, 3'd6, 8'h00, 8'hB0, P_NONE, "rst_msr");
      bus(0, 3'd1, 8'h00, 8'h00, P_NONE, "rst_ier");
      bus(0, 3'd7, 8'h00, 8'h00, P_NONE, "rst_scr");
      bus(0, 3'd4, 8'h00, 8'h00, P_NONE, "rst_mcr");
      expect_int(1'b0, "rst_int");
   endtask

   task automatic test_rda_flush();
      bus(1, 3'd2, 8'h41, 8'h00, P_NONE, "fcr_41");
      bus(1, 3'd1, 8'h01, 8'h00, P_NONE, "ier_01");
      rx_empty_i = 1'b0; rx_cnt_i = 5'd3;
      wait_cyc(2);
      expect_int(1'b0, "rda_cnt3");
      rx_cnt_i = 5'd4;
      #1 expect_int(1'b0, "rda_lag");
      @(negedge clk_i);
      expect_int(1'b1, "rda_cnt4");
      bus(0, 3'd2, 8'h00, 8'hC4, P_NONE, "iir_rda");
      bus(1, 3'd2, 8'h03, 8'h00, P_RXF, "fcr_rx_flush");
      rx_cnt_i = 5'd1;
      wait_cyc(2);
      bus(0, 3'd2, 8'h00, 8'hC4, P_NONE, "iir_trig1");
      bus(1, 3'd2, 8'h84, 8'h00, P_TXF, "fcr_tx_flush");
      bus(0, 3'd2, 8'h00, 8'h01, P_NONE, "iir_trig8_cnt1");
      rx_cnt_i = 5'd7;
      wait_cyc(2);
      expect_int(1'b0, "rda_cnt7");
      rx_cnt_i = 5'd8;
      wait_cyc(2);
      expect_int(1'b1, "rda_cnt8");
      bus(0, 3'd2, 8'h00, 8'h04, P_NONE, "iir_rda_fe0");
      rx_cnt_i = 5'd0; rx_empty_i = 1'b1;
      wait_cyc(2);
      expect_int(1'b0, "rda_drained");
   endtask

   task automatic test_timeout();
      bus(1, 3'd2, 8'hC0, 8'h00, P_NONE, "fcr_trig14");
      rx_empty_i = 1'b0; rx_cnt_i = 5'd1; rx_dat_i = 8'h77;
      // The count change clears the counter on the first edge, then it
      // climbs one per cycle; int_o follows the match by one more cycle.
      wait_cyc(TIMEOUT_CYC + 1);
      expect_int(1'b0, "cti_before");
      @(negedge clk_i);
      expect_int(1'b1, "cti_fire");
      bus(0, 3'd2, 8'h00, 8'h0C, P_NONE, "iir_cti");
      bus(0, 3'd0, 8'h00, 8'h77, P_POP, "rbr_pop");
      expect_int(1'b0, "cti_cleared");
      rx_empty_i = 1'b1; rx_cnt_i = 5'd0; rx_dat_i = 8'h3C;
      @(negedge clk_i);
      bus(0, 3'd0, 8'h00, 8'h3C, P_NONE, "rbr_empty");
   endtask

   task automatic test_thre();
      bus(1, 3'd1, 8'h02, 8'h00, P_NONE, "ier_etbei");
      expect_int(1'b1, "thre_int_set");
      bus(0, 3'd2, 8'h00, 8'h02, P_NONE, "iir_thre");
      bus(0, 3'd2, 8'h00, 8'h01, P_NONE, "iir_thre_cleared");
      expect_int(1'b0, "thre_int_clr");
      bus(1, 3'd0, 8'h5A, 8'h00, P_PUSH, "thr_5a");
      tx_full_i = 1'b1;
      bus(1, 3'd0, 8'hA5, 8'h00, P_NONE, "thr_full_drop");
      tx_full_i = 1'b0;
      tx_empty_i = 1'b0;
      @(negedge clk_i);
      tx_empty_i = 1'b1;
      wait_cyc(2);
      expect_int(1'b1, "thre_edge");
      bus(1, 3'd0, 8'h33, 8'h00, P_PUSH, "thr_clears");
      expect_int(1'b0, "thre_thr_clr");
      bus(0, 3'd2, 8'h00, 8'h01, P_NONE, "iir_after_thr");
   endtask

   task automatic test_dlab_loop();
      bus(1, 3'd3, 8'h83, 8'h00, P_NONE, "lcr_83");
      rx_empty_i = 1'b0; rx_dat_i = 8'h99;
      bus(0, 3'd0, 8'h00, 8'h01, P_NONE, "dll_reset_nopop");
      bus(1, 3'd0, 8'h12, 8'h00, P_NONE, "dll_wr_nopush");
      bus(1, 3'd1, 8'h34, 8'h00, P_NONE, "dlm_wr");
      bus(1, 3'd3, 8'h03, 8'h00, P_NONE, "lcr_03");
      bus(0, 3'd1, 8'h00, 8'h02, P_NONE, "ier_kept");
      bus(1, 3'd3, 8'h83, 8'h00, P_NONE, "lcr_83b");
      bus(0, 3'd0, 8'h00, 8'h12, P_NONE, "dll_rd");
      bus(0, 3'd1, 8'h00, 8'h34, P_NONE, "dlm_rd");
      bus(0, 3'd3, 8'h00, 8'h83, P_NONE, "lcr_rd");
      bus(1, 3'd3, 8'h03, 8'h00, P_NONE, "lcr_03b");
      bus(1, 3'd4, 8'h1A, 8'h00, P_NONE, "mcr_1a");
      bus(0, 3'd6, 8'h00, 8'h90, P_NONE, "msr_loop_1a");
      bus(0, 3'd4, 8'h00, 8'h1A, P_NONE, "mcr_rd");
      bus(1, 3'd4, 8'hFF, 8'h00, P_NONE, "mcr_ff");
      bus(0, 3'd4, 8'h00, 8'h1F, P_NONE, "mcr_reserved");
      bus(0, 3'd6, 8'h00, 8'hF0, P_NONE, "msr_loop_ff");
      bus(1, 3'd4, 8'h00, 8'h00, P_NONE, "mcr_00");
      bus(0, 3'd6, 8'h00, 8'hB0, P_NONE, "msr_noloop");
      tx_empty_i = 1'b0;
      bus(0, 3'd5, 8'h00, 8'h01, P_NONE, "lsr_dr");
      bus(1, 3'd5, 8'hFF, 8'h00, P_NONE, "lsr_wr");
      bus(0, 3'd5, 8'h00, 8'h01, P_NONE, "lsr_ro");
      bus(1, 3'd7, 8'hA5, 8'h00, P_NONE, "scr_wr");
      bus(0, 3'd7, 8'h00, 8'hA5, P_NONE, "scr_rd");
      rx_empty_i = 1'b1; tx_empty_i = 1'b1;
   endtask

   task automatic test_back_to_back();
      logic       exp_ack;
      logic [7:0] exp_dat;
      cpu_we_i = 1'b0; cpu_adr_i = 3'd7; cpu_dat_i = 8'h00; cpu_stb_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         exp_ack = (i % 2 == 0);
         exp_dat = exp_ack ? 8'hA5 : 8'h00;
         checks++;
         if (cpu_ack_o !== exp_ack || cpu_dat_o !== exp_dat) begin
            errors++;
            $display("FAIL b2b cycle %0d: ack=%b dat=0x%02h, required ack=%b dat=0x%02h",
                     i, cpu_ack_o, cpu_dat_o, exp_ack, exp_dat);
         end
      end
      cpu_stb_i = 1'b0;
      @(negedge clk_i);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_i = 1'b1; cpu_stb_i = 1'b0; cpu_we_i = 1'b0; cpu_adr_i = 3'd0; cpu_dat_i = 8'h00;
      rx_dat_i = 8'h00; rx_empty_i = 1'b1; rx_cnt_i = '0;
      tx_full_i = 1'b0; tx_empty_i = 1'b1;
      test_reset();
      test_rda_flush();
      test_timeout();
      test_thre();
      test_dlab_loop();
      test_back_to_back();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard: %0d entries left, required 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
